gray_ptr_receiver: RTL and testbench
====================================

// Module: gray_ptr_receiver
// PURPOSE
//  Receive end of the async-FIFO gray pointer crossing; counterpart to the
//  binary->gray encoder on the sending side.
//  - Synchronises a gray-coded pointer from the foreign clock domain into clk.
//  - Decodes it back to binary and reports the per-cycle pointer advance.
//  - Flags illegal multi-bit gray steps, which indicate a broken crossing.
//  - Instantiated twice per FIFO: write pointer into the read domain, read
//    pointer into the write domain.
// PARAMETERS
//  N            4   pointer width in bits (address bits + 1 wrap bit)
//  SYNC_STAGES  2   synchroniser flop depth, legal range 2..4
// PORTS
//  clk        in   1   local domain clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  gray_in    in   N   gray pointer from foreign domain (asynchronous to clk)
//  clear_err  in   1   synchronous clear of err_sticky
//  gray_sync  out  N   last synchroniser stage output
//  bin_out    out  N   registered binary pointer
//  bin_valid  out  1   high once the pipeline holds post-reset samples
//  delta      out  N   bin_out minus previous bin_out, modulo 2^N
//  step_err   out  1   one-cycle pulse: >1 gray bit changed between samples
//  err_sticky out  1   latched step_err
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (async assert, sync use after release):
//    - all flops cleared; every output is 0.
//    - gray 0 decodes to binary 0, so no spurious delta appears after reset.
//  - Pipeline:
//    - gray_in passes through SYNC_STAGES flops to give gray_sync.
//    - the decode of gray_sync is registered into bin_out.
//    - latency gray_in -> bin_out is SYNC_STAGES+1 cycles (3 by default).
//  - Decode: bin[N-1] = g[N-1]; bin[i] = bin[i+1] ^ g[i], for i = N-2 down to 0.
//  - delta is registered on the same edge as bin_out:
//    - delta = decoded - bin_out (old value), N-bit modular, wraps naturally.
//    - example: 15 -> 0 gives delta 1.
//  - bin_valid:
//    - a small counter, saturating, rises SYNC_STAGES+1 cycles after reset
//      release and stays high.
//    - while bin_valid is low, delta is forced to 0 and step_err is suppressed.
//  - step_err:
//    - compare gray_sync with its one-cycle-delayed copy.
//    - if popcount(XOR) > 1, step_err is high for exactly the cycle bin_out
//      takes the new value.
//    - a change of 0 or 1 bits is legal.
//  - err_sticky: set by step_err, cleared by clear_err; set wins on a
//    same-cycle conflict.
//  - Reset mid-operation: immediate clear of all state, including err_sticky;
//    the valid sequence restarts.
//  - No handshake; the block samples every cycle. The sender must change
//    gray_in by at most one bit per foreign-clock edge.
// STRUCTURE
//  - Shared include fifo_defs.vh:
//    - default PTR_W.
//    - SYNC_STAGES default.
//    - gray2bin / bin2gray functions, reused by encoder, receiver and benches.
//  - Sub-module gray_to_binary (combinational, parameter N) does the decode.
//  - Top level holds the sync chain, prev-gray register, valid counter,
//    delta/err logic.
//  - Mark the sync flops with the team's async-register attribute.
// TESTING  (N=4, SYNC_STAGES=2)
//  1. Reset: rst_n=0, gray_in=4'b1111 -> all outputs 0.
//     Release -> bin_out=4'b1010 and bin_valid=1 on cycle 3; delta=0.
//  2. Count: gray_in steps through the gray codes of 0..15 then 0, one per
//     cycle -> bin_out follows 3 cycles late, delta=1 every cycle including
//     15->0, step_err never set.
//  3. Hold: gray_in constant at 4'b0110 -> bin_out=4'b0100, delta=0.
//  4. Illegal step: gray 4'b0000 -> 4'b0011 -> step_err pulses 1 cycle,
//     bin_out=2, delta=2, err_sticky stays 1 until clear_err.
//  5. Conflict: clear_err=1 on the same cycle as a new step_err ->
//     err_sticky remains 1.
//  6. Mid-run reset:
//     - assert rst_n low during scenario 2 -> outputs 0 without waiting for
//       a clock edge.
//     - after release, bin_valid returns after 3 cycles; no stale delta.

Source files
------------

// File: rtl/gray_ptr_receiver_pkg.sv
// Shared definitions for the async-FIFO gray pointer crossing: default widths
// and the gray/binary conversion helpers used by encoder, receiver and benches.
package gray_ptr_receiver_pkg;

   localparam int PTR_W           = 4;
   localparam int SYNC_STAGES_DEF = 2;

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
      logic [PTR_W-1:0] bin;
      bin[PTR_W-1] = gray[PTR_W-1];
      for (int i = PTR_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary decode: each binary bit is the XOR of all gray
// bits at and above its position.
module gray_to_binary #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin[i] = ^gray[N-1:i];
   end

endmodule

// File: rtl/gray_ptr_receiver.sv
// Receive side of a gray pointer crossing: synchronise, decode to binary,
// report the per-cycle advance and flag illegal multi-bit gray steps.
module gray_ptr_receiver
   import gray_ptr_receiver_pkg::*;
#(
   parameter int N           = PTR_W,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF   // legal range 2..4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] gray_in,
   input  logic         clear_err,
   output logic [N-1:0] gray_sync,
   output logic [N-1:0] bin_out,
   output logic         bin_valid,
   output logic [N-1:0] delta,
   output logic         step_err,
   output logic         err_sticky
);

   localparam int VALID_AT = SYNC_STAGES + 1;
   localparam int CNT_W    = $clog2(VALID_AT + 1);

   (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_q [SYNC_STAGES];

   logic [N-1:0]     prev_gray;
   logic [N-1:0]     decoded;
   logic [N-1:0]     gray_diff;
   logic             multi_bit;
   logic [CNT_W-1:0] valid_cnt;

   // NOTE: the sync chain is a handful of flops, not a RAM, so every stage is
   // cleared by reset; sequential state always uses non-blocking assignment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign gray_sync = sync_q[SYNC_STAGES-1];

   gray_to_binary #(
      .N (N)
   ) u_decode (
      .gray (gray_sync),
      .bin  (decoded)
   );

   // More than one bit set in the XOR means the crossing skipped a gray code.
   assign gray_diff = gray_sync ^ prev_gray;
   assign multi_bit = (gray_diff & (gray_diff - N'(1))) != '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_cnt <= '0;
      end else if (valid_cnt != CNT_W'(VALID_AT)) begin
         valid_cnt <= valid_cnt + CNT_W'(1);
      end
   end

   assign bin_valid = (valid_cnt == CNT_W'(VALID_AT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_gray  <= '0;
         bin_out    <= '0;
         delta      <= '0;
         step_err   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         prev_gray <= gray_sync;
         bin_out   <= decoded;
         // Until the pipeline holds real samples, the reset zeros are not a
         // genuine previous pointer, so delta and step_err are held off.
         delta     <= bin_valid ? (decoded - bin_out) : '0;
         step_err  <= bin_valid & multi_bit;
         // Set has priority over clear.
         err_sticky <= step_err | (err_sticky & ~clear_err);
      end
   end

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Self-checking bench for gray_ptr_receiver (N=4, SYNC_STAGES=2) using a
// due-cycle scoreboard filled when each gray value is driven.
module tb_gray_ptr_receiver;

   localparam int N   = 4;
   localparam int SS  = 2;
   localparam int LAT = SS + 1;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic [N-1:0] gray_in   = '1;
   logic         clear_err = 1'b0;
   logic [N-1:0] gray_sync;
   logic [N-1:0] bin_out;
   logic         bin_valid;
   logic [N-1:0] delta;
   logic         step_err;
   logic         err_sticky;

   gray_ptr_receiver #(
      .N           (N),
      .SYNC_STAGES (SS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray_in    (gray_in),
      .clear_err  (clear_err),
      .gray_sync  (gray_sync),
      .bin_out    (bin_out),
      .bin_valid  (bin_valid),
      .delta      (delta),
      .step_err   (step_err),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [N-1:0] bin;
      logic [N-1:0] delta;
      logic         err;
   } exp_t;

   exp_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    rel_cyc  = 0;
   string phase    = "init";

   logic [N-1:0] m_prev_g, m_prev_bin, exp_bin, exp_delta;
   logic         exp_step, exp_sticky, step_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s/%s: got %0h expected %0h at t=%0t", phase, tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] to_bin(input logic [N-1:0] g);
      logic [N-1:0] b;
      for (int i = 0; i < N; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic bit multi(input logic [N-1:0] x);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(x[i]);
      return c > 1;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      rel_cyc    = 0;
      m_prev_g   = '0;
      m_prev_bin = '0;
      exp_bin    = '0;
      exp_delta  = '0;
      exp_step   = 1'b0;
      exp_sticky = 1'b0;
      step_prev  = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gray_sync"}, gray_sync, 0);
      check({tag, "_bin_out"}, bin_out, 0);
      check({tag, "_bin_valid"}, bin_valid, 0);
      check({tag, "_delta"}, delta, 0);
      check({tag, "_step_err"}, step_err, 0);
      check({tag, "_err_sticky"}, err_sticky, 0);
   endtask

   // Called at the falling edge after edge number rel_cyc since release.
   task automatic sample();
      exp_t e;
      exp_sticky = step_prev | (exp_sticky & ~clear_err);
      exp_delta  = '0;
      exp_step   = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == rel_cyc) begin
         e       = exp_q.pop_front();
         exp_bin = e.bin;
         if (rel_cyc > LAT) begin
            exp_delta = e.delta;
            exp_step  = e.err;
         end
      end
      step_prev = exp_step;
      check("bin_out", bin_out, exp_bin);
      check("bin_valid", bin_valid, rel_cyc >= LAT);
      check("delta", delta, exp_delta);
      check("step_err", step_err, exp_step);
      check("err_sticky", err_sticky, exp_sticky);
   endtask

   task automatic tick(input logic [N-1:0] g, input logic clr);
      exp_t e;
      gray_in   = g;
      clear_err = clr;
      e.due     = rel_cyc + LAT;
      e.bin     = to_bin(g);
      e.delta   = e.bin - m_prev_bin;
      e.err     = multi(g ^ m_prev_g);
      m_prev_g   = g;
      m_prev_bin = e.bin;
      exp_q.push_back(e);
      @(posedge clk);
      rel_cyc++;
      @(negedge clk);
      sample();
   endtask

   // Asserts reset between clock edges and checks the outputs clear at once.
   task automatic do_reset(input logic [N-1:0] g_hold, input int cycles);
      #2;
      rst_n     = 1'b0;
      gray_in   = g_hold;
      clear_err = 1'b0;
      #1;
      check_zero("async");
      repeat (cycles) @(negedge clk);
      check_zero("held");
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();

      phase = "reset";
      do_reset(4'b1111, 3);
      for (int i = 0; i < 5; i++) tick(4'b1111, 1'b0);
      check("bin_after_release", bin_out, 4'b1010);

      phase = "count";
      for (int b = 11; b < 16; b++) tick(to_gray(N'(b)), 1'b0);
      for (int b = 0; b < 16; b++) tick(to_gray(N'(b)), 1'b0);
      tick(4'b0000, 1'b0);
      for (int i = 0; i < LAT; i++) tick(4'b0000, 1'b0);

      phase = "hold";
      for (int b = 1; b < 4; b++) tick(to_gray(N'(b)), 1'b0);
      for (int i = 0; i < 6; i++) tick(4'b0110, 1'b0);
      check("hold_bin", bin_out, 4'b0100);

      phase = "illegal";
      for (int b = 3; b >= 0; b--) tick(to_gray(N'(b)), 1'b0);
      for (int i = 0; i < 4; i++) tick(4'b0000, 1'b0);
      for (int i = 0; i < 6; i++) tick(4'b0011, 1'b0);
      check("sticky_held", err_sticky, 1);
      tick(4'b0011, 1'b1);
      for (int i = 0; i < 2; i++) tick(4'b0011, 1'b0);
      check("sticky_cleared", err_sticky, 0);

      phase = "conflict";
      for (int i = 0; i < 4; i++) tick(4'b0000, 1'b1);
      for (int i = 0; i < 2; i++) tick(4'b0000, 1'b0);
      check("sticky_kept", err_sticky, 1);

      phase = "midrun";
      for (int b = 1; b < 10; b++) tick(to_gray(N'(b)), 1'b0);
      do_reset(gray_in, 2);
      for (int b = 10; b < 16; b++) tick(to_gray(N'(b)), 1'b0);
      for (int b = 0; b < 4; b++) tick(to_gray(N'(b)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
